// File: rtl/vdp18_pkg.sv
// Shared types for the VDP18 host bus sequencer.
// Access states and the queued host request bundle.
package vdp18_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    GAP
  } seq_state_t;

  typedef struct packed {
    logic       wr;
    logic       mode;
    logic [7:0] data;
  } bus_req_t;

endpackage

// File: rtl/vdp18_bus_fifo.sv
// Synchronous request FIFO for the VDP18 bus sequencer.
// Power-of-two depth; pushes while full and pops while empty are dropped.
module vdp18_bus_fifo
  import vdp18_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  bus_req_t wdata,
  input  logic     pop,
  output bus_req_t rdata,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  bus_req_t      mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == CNT_FULL);
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/vdp18_bus_seq.sv
// Host-to-VDP18 bus sequencer: FIFO-fed csw_n/csr_n access timing.
// Define VDP18_BUS_SEQ_VRAM_PACE_EN for a separate data-port gap (DATA_GAP_TICKS).
module vdp18_bus_seq
  import vdp18_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STROBE_TICKS = 4,
  parameter int GAP_TICKS    = 32
`ifdef VDP18_BUS_SEQ_VRAM_PACE_EN
  ,
  parameter int DATA_GAP_TICKS = 64
`endif
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clk_en_10m7_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_wr_i,
  input  logic       req_mode_i,
  input  logic [7:0] req_data_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_data_o,
  output logic       busy_o,
  output logic       csw_n_o,
  output logic       csr_n_o,
  output logic       mode_o,
  output logic [7:0] cd_o,
  input  logic [7:0] cd_i
);

  localparam logic [7:0] STROBE_LD = 8'(STROBE_TICKS - 1);
  localparam logic [7:0] GAP_LD    = 8'(GAP_TICKS - 1);

  seq_state_t state, state_n;
  logic [7:0] cnt, cnt_n;
  logic       wr_q, wr_n;
  logic       mode_q, mode_n;
  logic [7:0] cd_q, cd_n;
  logic       rsp_valid_q, rsp_valid_n;
  logic [7:0] rsp_data_q, rsp_data_n;
  logic [7:0] gap_ld;
  logic       pop;
  logic       full;
  logic       empty;
  bus_req_t   head;
  bus_req_t   wreq;

  assign wreq = '{wr: req_wr_i, mode: req_mode_i, data: req_data_i};

  vdp18_bus_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk_i),
    .reset(reset_i),
    .push (req_valid_i),
    .wdata(wreq),
    .pop  (pop),
    .rdata(head),
    .full (full),
    .empty(empty)
  );

`ifdef VDP18_BUS_SEQ_VRAM_PACE_EN
  localparam logic [7:0] DATA_LD = 8'(DATA_GAP_TICKS - 1);
  assign gap_ld = mode_q ? GAP_LD : DATA_LD;
`else
  assign gap_ld = GAP_LD;
`endif

  // Counters load N-1 on entry so the exit tick is the N-th one.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    pop         = 1'b0;
    wr_n        = wr_q;
    mode_n      = mode_q;
    cd_n        = cd_q;
    rsp_valid_n = 1'b0;
    rsp_data_n  = rsp_data_q;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          wr_n    = head.wr;
          mode_n  = head.mode;
          cd_n    = head.data;
          state_n = SETUP;
        end
      end
      SETUP: begin
        if (clk_en_10m7_i) begin
          state_n = STROBE;
          cnt_n   = STROBE_LD;
        end
      end
      STROBE: begin
        if (clk_en_10m7_i) begin
          if (cnt == 8'd0) begin
            state_n = HOLD;
            if (!wr_q) begin
              rsp_valid_n = 1'b1;
              rsp_data_n  = cd_i;
            end
          end else begin
            cnt_n = cnt - 8'd1;
          end
        end
      end
      HOLD: begin
        if (clk_en_10m7_i) begin
          state_n = GAP;
          cnt_n   = gap_ld;
        end
      end
      GAP: begin
        if (clk_en_10m7_i) begin
          if (cnt == 8'd0) state_n = IDLE;
          else cnt_n = cnt - 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= IDLE;
      cnt         <= '0;
      wr_q        <= 1'b0;
      mode_q      <= 1'b0;
      cd_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      wr_q        <= wr_n;
      mode_q      <= mode_n;
      cd_q        <= cd_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_data_q  <= rsp_data_n;
    end
  end

  // Strobes decode from state only, so they can never overlap.
  assign csw_n_o     = reset_i | ~((state == STROBE) & wr_q);
  assign csr_n_o     = reset_i | ~((state == STROBE) & ~wr_q);
  assign mode_o      = mode_q;
  assign cd_o        = cd_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign req_ready_o = ~full;
  assign busy_o      = (state != IDLE) | ~empty;

endmodule

// File: tb/tb_vdp18_bus_seq.sv
// Self-checking bench for vdp18_bus_seq: vector table, corner
// sequences and randomized traffic against a queue-based model.
module tb_vdp18_bus_seq;
  import vdp18_pkg::*;

  localparam int STB = 4;
  localparam int GAP = 32;
`ifdef VDP18_BUS_SEQ_VRAM_PACE_EN
  localparam int DGAP = 64;
`else
  localparam int DGAP = GAP;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk_en = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_wr = 1'b0;
  logic       req_mode = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       csw_n;
  logic       csr_n;
  logic       mode_o;
  logic [7:0] cd_o;
  logic [7:0] cd_in = 8'h00;

  vdp18_bus_seq #(
    .FIFO_DEPTH  (4),
    .STROBE_TICKS(STB),
    .GAP_TICKS   (GAP)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .clk_en_10m7_i(clk_en),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_wr_i     (req_wr),
    .req_mode_i   (req_mode),
    .req_data_i   (req_data),
    .rsp_valid_o  (rsp_valid),
    .rsp_data_o   (rsp_data),
    .busy_o       (busy),
    .csw_n_o      (csw_n),
    .csr_n_o      (csr_n),
    .mode_o       (mode_o),
    .cd_o         (cd_o),
    .cd_i         (cd_in)
  );

  typedef struct {
    logic       wr;
    logic       mode;
    logic [7:0] data;
    logic [7:0] cdv;
    logic       exp_wr;
    logic       exp_mode;
    logic [7:0] exp_cd;
    int         exp_nrsp;
    logic [7:0] exp_rsp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int en_mode = 0;
  int ph = 0;
  int ticks = 0;
  bit model_en = 1'b1;
  bit rand_cd = 1'b0;

  bus_req_t   model_q[$];
  logic [7:0] rsp_q[$];

  int         falls = 0;
  int         rsp_cnt = 0;
  int         last_fall = 0;
  int         prev_fall = 0;
  int         last_len = 0;
  logic       last_wr = 1'b0;
  logic       last_mode = 1'b0;
  logic [7:0] last_cd = 8'h00;
  logic [7:0] last_rsp = 8'h00;
  logic       pw = 1'b1;
  logic       pr = 1'b1;
  logic       prv = 1'b0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Tick source: off, every second clock, or random 1-in-3.
  always @(negedge clk) begin
    ph++;
    case (en_mode)
      1:       clk_en = ph[0];
      2:       clk_en = ($urandom_range(0, 2) == 0);
      default: clk_en = 1'b0;
    endcase
  end

  always @(posedge clk) begin
    if (clk_en) ticks <= ticks + 1;
  end

  // Bus monitor and reference model: strobes in request order.
  always @(negedge clk) begin
    bus_req_t e;
    if (reset) begin
      pw  = 1'b1;
      pr  = 1'b1;
      prv = 1'b0;
    end else begin
      chk("strobe_overlap", int'(!csw_n && !csr_n), 0);
      if ((!csw_n && pw) || (!csr_n && pr)) begin
        falls++;
        prev_fall = last_fall;
        last_fall = ticks;
        last_wr   = !csw_n;
        last_mode = mode_o;
        last_cd   = cd_o;
        if (!csr_n) begin
          if (rand_cd) cd_in = 8'($urandom);
          if (model_en) rsp_q.push_back(cd_in);
        end
        if (model_en) begin
          chk("strobe_expected", int'(model_q.size() != 0), 1);
          if (model_q.size() != 0) begin
            e = model_q.pop_front();
            chk("strobe_dir", int'(!csw_n), int'(e.wr));
            chk("strobe_mode", int'(mode_o), int'(e.mode));
            chk("strobe_cd", int'(cd_o), int'(e.data));
          end
        end
      end
      if ((csw_n && !pw) || (csr_n && !pr)) begin
        last_len = ticks - last_fall;
        if (model_en) chk("strobe_len", last_len, STB);
      end
      if (rsp_valid) begin
        rsp_cnt++;
        last_rsp = rsp_data;
        chk("rsp_pulse_width", int'(prv), 0);
        if (model_en) begin
          chk("rsp_expected", int'(rsp_q.size() != 0), 1);
          if (rsp_q.size() != 0)
            chk("rsp_data", int'(rsp_data), int'(rsp_q.pop_front()));
        end
      end
      pw  = csw_n;
      pr  = csr_n;
      prv = rsp_valid;
    end
  end

  task automatic push(input logic wr, input logic mode,
                      input logic [7:0] d, output bit acc);
    bus_req_t r;
    @(negedge clk);
    req_valid = 1'b1;
    req_wr    = wr;
    req_mode  = mode;
    req_data  = d;
    acc       = req_ready;
    r.wr      = wr;
    r.mode    = mode;
    r.data    = d;
    if (acc) model_q.push_back(r);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < budget);
    chk("idle_timeout", int'(busy), 0);
  endtask

  initial begin
    vec_t vecs[4];
    bit   acc;
    int   f0, f1, r0, n, t0;

    vecs[0] = '{1'b1, 1'b1, 8'h81, 8'h00, 1'b1, 1'b1, 8'h81, 0, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 8'h00, 8'hA5, 1'b0, 1'b1, 8'h00, 1, 8'hA5};
    vecs[2] = '{1'b1, 1'b0, 8'h3C, 8'h00, 1'b1, 1'b0, 8'h3C, 0, 8'h00};
    vecs[3] = '{1'b0, 1'b0, 8'h42, 8'h5A, 1'b0, 1'b0, 8'h42, 1, 8'h5A};

    repeat (2) @(negedge clk);
    chk("rst_csw_n", int'(csw_n), 1);
    chk("rst_csr_n", int'(csr_n), 1);
    chk("rst_mode", int'(mode_o), 0);
    chk("rst_cd", int'(cd_o), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_data", int'(rsp_data), 0);
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b0;
    en_mode = 1;

    for (int i = 0; i < 4; i++) begin
      f0 = falls;
      r0 = rsp_cnt;
      cd_in = vecs[i].cdv;
      push(vecs[i].wr, vecs[i].mode, vecs[i].data, acc);
      chk("vec_accept", int'(acc), 1);
      wait_idle(2000);
      chk("vec_strobes", falls - f0, 1);
      chk("vec_dir", int'(last_wr), int'(vecs[i].exp_wr));
      chk("vec_mode", int'(last_mode), int'(vecs[i].exp_mode));
      chk("vec_cd", int'(last_cd), int'(vecs[i].exp_cd));
      chk("vec_len", last_len, STB);
      chk("vec_rsp_count", rsp_cnt - r0, vecs[i].exp_nrsp);
      if (vecs[i].exp_nrsp != 0)
        chk("vec_rsp_data", int'(last_rsp), int'(vecs[i].exp_rsp));
    end

    push(1'b1, 1'b1, 8'h11, acc);
    push(1'b1, 1'b1, 8'h22, acc);
    wait_idle(3000);
    chk("spacing_mode1", last_fall - prev_fall, 2 + STB + GAP);
    push(1'b1, 1'b0, 8'h33, acc);
    push(1'b1, 1'b0, 8'h44, acc);
    wait_idle(3000);
    chk("spacing_mode0", last_fall - prev_fall, 2 + STB + DGAP);

    // Park the FSM in GAP with ticks stopped, then overfill the FIFO.
    f0 = falls;
    push(1'b1, 1'b1, 8'h01, acc);
    n = 0;
    while (!(falls == f0 + 1 && csw_n) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("full_setup_timeout", int'(n < 500), 1);
    repeat (6) @(negedge clk);
    en_mode = 0;
    repeat (2) @(negedge clk);
    f1 = falls;
    for (int i = 0; i < 5; i++) begin
      push(1'b1, 1'b1, 8'(8'h10 + i), acc);
      chk("full_accept", int'(acc), int'(i < 4));
      if (i == 3) begin
        @(negedge clk);
        chk("full_ready", int'(req_ready), 0);
      end
    end
    chk("full_busy", int'(busy), 1);
    chk("full_no_strobe_while_stalled", falls - f1, 0);
    en_mode = 1;
    wait_idle(5000);
    chk("full_strobes", falls - f1, 4);

    en_mode = 2;
    rand_cd = 1'b1;
    for (int i = 0; i < 40; i++) begin
      push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom), acc);
      repeat ($urandom_range(0, 60)) @(negedge clk);
    end
    wait_idle(40000);
    chk("rand_model_drained", model_q.size(), 0);
    chk("rand_rsp_drained", rsp_q.size(), 0);
    rand_cd = 1'b0;

    // Abort a read in its second strobe tick.
    model_en = 1'b0;
    en_mode = 1;
    cd_in = 8'h77;
    f0 = falls;
    r0 = rsp_cnt;
    push(1'b0, 1'b1, 8'h00, acc);
    n = 0;
    while (csr_n && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("abort_read_start", int'(csr_n), 0);
    t0 = ticks;
    n = 0;
    while (ticks == t0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("abort_in_strobe", int'(csr_n), 0);
    reset = 1'b1;
    #1;
    chk("abort_csr_n", int'(csr_n), 1);
    chk("abort_csw_n", int'(csw_n), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready", int'(req_ready), 1);
    chk("abort_rsp_valid", int'(rsp_valid), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    chk("abort_no_rsp", rsp_cnt - r0, 0);
    chk("abort_no_restart", falls - f0, 1);
    chk("abort_idle", int'(busy), 0);
    chk("abort_rsp_data", int'(rsp_data), 0);
    model_q.delete();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
